// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MDU issue/stall controller: operation encodings,
// FSM state type, default latencies and latency legalisation helpers.
package mdu_defs;

    typedef enum logic [3:0] {
        E_NONE  = 4'd0,
        E_MULT  = 4'd1,
        E_MULTU = 4'd2,
        E_DIV   = 4'd3,
        E_DIVU  = 4'd4,
        E_MTLO  = 4'd5,
        E_MTHI  = 4'd6,
        E_MFLO  = 4'd7,
        E_MFHI  = 4'd8
    } e_md_op_e;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MTHI  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int unsigned DEF_MULT_LAT = 32'd5;
    localparam int unsigned DEF_DIV_LAT  = 32'd10;

    // A latency of zero cannot be represented by the busy window; it behaves as one.
    function automatic int unsigned legal_lat(input int unsigned lat);
        return (lat < 32'd1) ? 32'd1 : lat;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned mx;
        mx = (a > b) ? a : b;
        return $clog2(mx + 32'd1);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-to-controller bundle: E/D stage requests in, MDU control and
// hazard status out.
interface mdu_ctrl_if;

    logic       e_valid;
    logic [3:0] e_md_op;
    logic       d_is_md;
    logic       mdu_start;
    logic [2:0] mdu_op;
    logic       mdu_rdsel;
    logic       busy;
    logic       stall_md;
    logic       conflict;

    modport master (
        output e_valid, e_md_op, d_is_md,
        input  mdu_start, mdu_op, mdu_rdsel, busy, stall_md, conflict
    );

    modport slave (
        input  e_valid, e_md_op, d_is_md,
        output mdu_start, mdu_op, mdu_rdsel, busy, stall_md, conflict
    );

endinterface

// File: rtl/mdu_lat_cnt.sv
// Loadable down-counter that flags the final busy cycle of an MDU operation.
module mdu_lat_cnt #(
    parameter int unsigned WIDTH = 32'd4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins over decrement; saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// MDU issue controller: starts multiply/divide operations from E, tracks the
// busy window, stalls MDU instructions in D and records illegal overlaps.
module mdu_ctrl
    import mdu_defs::*;
#(
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave bus
);

    localparam int unsigned M_LAT = legal_lat(MULT_LAT);
    localparam int unsigned D_LAT = legal_lat(DIV_LAT);
    localparam int unsigned CNT_W = cnt_width(M_LAT, D_LAT);
    localparam logic [CNT_W-1:0] M_LOAD = CNT_W'(M_LAT);
    localparam logic [CNT_W-1:0] D_LOAD = CNT_W'(D_LAT);

    mdu_state_e state_q;
    mdu_state_e state_d;
    logic       busy_q;
    logic       busy_d;
    logic       conflict_q;
    logic       conflict_d;

    logic             issuable_s;
    logic             md_class_s;
    logic             long_op_s;
    logic             move_op_s;
    logic             is_mult_s;
    logic             start_s;
    logic [2:0]       op_s;
    logic             rdsel_s;
    logic             last_s;
    logic [CNT_W-1:0] load_val_s;

    // Decode the E-stage request against the current FSM state.
    always_comb begin
        issuable_s = bus.e_valid && (state_q == ST_IDLE);
        md_class_s = (bus.e_md_op >= E_MULT) && (bus.e_md_op <= E_MFHI);
        long_op_s  = (bus.e_md_op >= E_MULT) && (bus.e_md_op <= E_DIVU);
        move_op_s  = (bus.e_md_op == E_MTLO) || (bus.e_md_op == E_MTHI);
        is_mult_s  = (bus.e_md_op == E_MULT) || (bus.e_md_op == E_MULTU);
        start_s    = issuable_s && long_op_s;
        if (issuable_s && (long_op_s || move_op_s)) begin
            op_s = bus.e_md_op[2:0];
        end else begin
            op_s = MDU_NOP;
        end
        rdsel_s    = bus.e_valid && (bus.e_md_op == E_MFHI);
        load_val_s = is_mult_s ? M_LOAD : D_LOAD;
    end

    // FSM next state and sticky overlap detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = is_mult_s ? ST_MULT : ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                if (last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        if (bus.e_valid && md_class_s && (state_q != ST_IDLE)) begin
            conflict_d = 1'b1;
        end else begin
            conflict_d = conflict_q;
        end
    end

    // State, busy and conflict registers; reset overrides any same-cycle start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    mdu_lat_cnt #(
        .WIDTH (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start_s),
        .load_val_i (load_val_s),
        .dec_i      (state_q != ST_IDLE),
        .last_o     (last_s)
    );

    assign bus.mdu_start = start_s;
    assign bus.mdu_op    = op_s;
    assign bus.mdu_rdsel = rdsel_s;
    assign bus.busy      = busy_q;
    assign bus.stall_md  = bus.d_is_md && (start_s || busy_q);
    assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: cycle-level reference model of the busy
// window and conflict flag, directed scenarios with literal expectations, then random traffic.
module tb_mdu_ctrl;

    localparam int ML = 5;
    localparam int DL = 10;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   check_en = 1'b0;

    mdu_ctrl_if bus_if ();

    mdu_ctrl #(
        .MULT_LAT (ML),
        .DIV_LAT  (DL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic d);
        bus_if.e_valid = v;
        bus_if.e_md_op = op;
        bus_if.d_is_md = d;
    endtask

    // Reference model: the MDU is busy for cycles start+1 .. start+LAT; conflict is sticky.
    int cyc      = 0;
    int busy_end = -1;
    bit conf_m   = 1'b0;

    always @(negedge clk) begin
        logic [3:0] op;
        bit busy_m, iss, ex_start, ex_rdsel, ex_stall, md;
        logic [2:0] ex_op;
        op       = bus_if.e_md_op;
        busy_m   = (cyc <= busy_end);
        iss      = bus_if.e_valid && !busy_m;
        md       = (op >= 4'd1) && (op <= 4'd8);
        ex_start = iss && (op >= 4'd1) && (op <= 4'd4);
        ex_op    = (iss && (op >= 4'd1) && (op <= 4'd6)) ? op[2:0] : 3'd0;
        ex_rdsel = bus_if.e_valid && (op == 4'd8);
        ex_stall = bus_if.d_is_md && (ex_start || busy_m);
        if (check_en) begin
            chk("m_start",    bus_if.mdu_start, ex_start);
            chk("m_op",       bus_if.mdu_op,    ex_op);
            chk("m_rdsel",    bus_if.mdu_rdsel, ex_rdsel);
            chk("m_busy",     bus_if.busy,      busy_m);
            chk("m_stall",    bus_if.stall_md,  ex_stall);
            chk("m_conflict", bus_if.conflict,  conf_m);
        end
        if (reset) begin
            busy_end = cyc;
            conf_m   = 1'b0;
        end else begin
            if (ex_start) busy_end = cyc + ((op <= 4'd2) ? ML : DL);
            if (bus_if.e_valid && md && busy_m) conf_m = 1'b1;
        end
        cyc++;
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;

        // mult: start pulse now, busy for 5 cycles, idle on the 6th
        drive(1'b1, 4'd1, 1'b0);
        @(negedge clk);
        chk("mult_start", bus_if.mdu_start, 1'b1);
        chk("mult_op", bus_if.mdu_op, 3'd1);
        chk("mult_busy_T0", bus_if.busy, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(); drive(1'b0, 4'd0, 1'b0);
            @(negedge clk);
            chk("mult_busy_win", bus_if.busy, 1'b1);
        end
        step();
        @(negedge clk);
        chk("mult_done", bus_if.busy, 1'b0);

        // divu with D holding an MDU op: stall T..T+10, next divu issues at T+11
        step(); drive(1'b1, 4'd4, 1'b1);
        @(negedge clk);
        chk("divu_stall_T0", bus_if.stall_md, 1'b1);
        chk("divu_start", bus_if.mdu_start, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(); drive(1'b0, 4'd0, 1'b1);
            @(negedge clk);
            chk("divu_stall_win", bus_if.stall_md, 1'b1);
        end
        step(); drive(1'b1, 4'd4, 1'b0);
        @(negedge clk);
        chk("divu_idle_T11", bus_if.busy, 1'b0);
        chk("divu_stall_T11", bus_if.stall_md, 1'b0);
        chk("divu2_start", bus_if.mdu_start, 1'b1);
        chk("divu2_op", bus_if.mdu_op, 3'd4);
        step(); drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("divu2_busy", bus_if.busy, 1'b1);
        repeat (10) step();

        // mfhi / mthi / mflo while idle
        drive(1'b1, 4'd8, 1'b0);
        @(negedge clk);
        chk("mfhi_rdsel", bus_if.mdu_rdsel, 1'b1);
        chk("mfhi_op", bus_if.mdu_op, 3'd0);
        chk("mfhi_start", bus_if.mdu_start, 1'b0);
        step(); drive(1'b1, 4'd6, 1'b0);
        @(negedge clk);
        chk("mthi_op", bus_if.mdu_op, 3'd6);
        chk("mthi_start", bus_if.mdu_start, 1'b0);
        step(); drive(1'b1, 4'd7, 1'b0);
        @(negedge clk);
        chk("mthi_busy", bus_if.busy, 1'b0);
        chk("mflo_rdsel", bus_if.mdu_rdsel, 1'b0);

        // e_valid low masks the op entirely
        step(); drive(1'b0, 4'd1, 1'b1);
        @(negedge clk);
        chk("bubble_start", bus_if.mdu_start, 1'b0);
        chk("bubble_stall", bus_if.stall_md, 1'b0);
        step(); drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("bubble_busy", bus_if.busy, 1'b0);

        // div forced into E during a mult: conflict, no start, mult finishes on time
        step(); drive(1'b1, 4'd1, 1'b0);
        step(); drive(1'b0, 4'd0, 1'b0);
        step(); drive(1'b1, 4'd3, 1'b0);
        @(negedge clk);
        chk("conf_nostart", bus_if.mdu_start, 1'b0);
        chk("conf_op", bus_if.mdu_op, 3'd0);
        chk("conf_pre", bus_if.conflict, 1'b0);
        step(); drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("conf_set", bus_if.conflict, 1'b1);
        step(); step();
        @(negedge clk);
        chk("conf_mult_T5", bus_if.busy, 1'b1);
        step();
        @(negedge clk);
        chk("conf_mult_T6", bus_if.busy, 1'b0);
        chk("conf_sticky", bus_if.conflict, 1'b1);

        // reset in the middle of a div, then a fresh mult
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        @(negedge clk);
        chk("rst_clr_conf", bus_if.conflict, 1'b0);
        step(); drive(1'b1, 4'd3, 1'b0);
        step(); drive(1'b0, 4'd0, 1'b0);
        step();
        step(); reset = 1'b1;
        @(negedge clk);
        chk("rst_div_T3", bus_if.busy, 1'b1);
        step(); reset = 1'b0; drive(1'b1, 4'd1, 1'b0);
        @(negedge clk);
        chk("rst_div_T4", bus_if.busy, 1'b0);
        chk("rst_mult_start", bus_if.mdu_start, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(); drive(1'b0, 4'd0, 1'b0);
            @(negedge clk);
            chk("rst_mult_busy", bus_if.busy, 1'b1);
        end
        step();
        @(negedge clk);
        chk("rst_mult_done", bus_if.busy, 1'b0);

        // reset beats a simultaneous start
        step(); reset = 1'b1; drive(1'b1, 4'd1, 1'b0);
        step(); reset = 1'b0; drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("rst_vs_start", bus_if.busy, 1'b0);

        // random traffic, checked cycle by cycle by the model
        for (int n = 0; n < 3000; n++) begin
            step();
            reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8)),
                  1'($urandom_range(0, 1)));
        end
        step(); reset = 1'b0; drive(1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
